// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and its datapath/memory.
// The master side is the controller: it samples the opcode, ALU zero flag
// and memory handshake, and drives every datapath enable and mux select.
// The slave side is the datapath, which supplies those inputs and consumes
// the controls.

interface multicycle_controller_if;
  logic [6:0] op;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [3:0] state;
  logic       instr_done;
  logic       err;

  modport master (
    input  op, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, state, instr_done, err
  );

  modport slave (
    output op, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, state, instr_done, err
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM with a memory-wait watchdog.
// Optional feature macro: JALR_SUPPORT_EN adds the JALR_ADR/JALR_JMP path.
// Without it, opcode 1100111 is treated as illegal.
//
// The control word for the current state is registered alongside the state.
// The few outputs that must follow an input within the same cycle
// (PCWrite/IRWrite on mem_ready, PCWrite on Zero, instr_done on mem_ready)
// are a registered qualifier ANDed with that input.
// A watchdog counts consecutive mem_ready=0 cycles in the three memory-wait
// states and forces ERROR when the count reaches MEM_TIMEOUT. ERROR is
// sticky until reset.

module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  localparam logic [3:0] TIMEOUT = MEM_TIMEOUT[3:0];

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
`ifdef JALR_SUPPORT_EN
  localparam logic [6:0] OP_JALR   = 7'b1100111;
`endif

`ifdef JALR_SUPPORT_EN
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    JALR_ADR = 4'd11,
    JALR_JMP = 4'd12,
    ERROR    = 4'd13
  } state_t;
`else
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    ERROR    = 4'd13
  } state_t;
`endif

  // Registered control word; the *On* fields are qualifiers that are
  // combined with a live input before reaching the port.
  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteOnReady;
    logic       pcWriteOnZero;
    logic       adrSrc;
    logic       memWrite;
    logic       irWriteOnReady;
    logic       regWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       doneAlways;
    logic       doneOnReady;
  } ctrl_t;

  state_t     state_q, state_d;
  logic [3:0] waitCnt_q, waitCnt_d;
  logic       err_q;
  ctrl_t      ctrl_q;

  logic       waitState;
  logic       timedOut;

  // Control word produced while sitting in a given state
  function automatic ctrl_t ctrlFor(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.aluSrcB        = 2'b10;
        c.resultSrc      = 2'b10;
        c.irWriteOnReady = 1'b1;
        c.pcWriteOnReady = 1'b1;
      end
      DECODE: begin
        c.aluSrcA = 2'b01;
        c.aluSrcB = 2'b01;
      end
      MEMADR: begin
        c.aluSrcA = 2'b10;
        c.aluSrcB = 2'b01;
      end
      MEMREAD: begin
        c.adrSrc = 1'b1;
      end
      MEMWB: begin
        c.resultSrc  = 2'b01;
        c.regWrite   = 1'b1;
        c.doneAlways = 1'b1;
      end
      MEMWRITE: begin
        c.adrSrc      = 1'b1;
        c.memWrite    = 1'b1;
        c.doneOnReady = 1'b1;
      end
      EXECUTER: begin
        c.aluSrcA = 2'b10;
        c.aluOp   = 2'b10;
      end
      EXECUTEI: begin
        c.aluSrcA = 2'b10;
        c.aluSrcB = 2'b01;
        c.aluOp   = 2'b10;
      end
      ALUWB: begin
        c.regWrite   = 1'b1;
        c.doneAlways = 1'b1;
      end
      BEQ: begin
        c.aluSrcA       = 2'b10;
        c.aluOp         = 2'b01;
        c.pcWriteOnZero = 1'b1;
        c.doneAlways    = 1'b1;
      end
      JAL: begin
        c.aluSrcA = 2'b01;
        c.aluSrcB = 2'b10;
        c.pcWrite = 1'b1;
      end
`ifdef JALR_SUPPORT_EN
      JALR_ADR: begin
        c.aluSrcA = 2'b10;
        c.aluSrcB = 2'b01;
      end
      JALR_JMP: begin
        c.aluSrcA = 2'b01;
        c.aluSrcB = 2'b10;
        c.pcWrite = 1'b1;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  assign waitState = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
  assign timedOut  = (waitCnt_q == TIMEOUT) && !bus.mem_ready;

  // Next-state selection; the watchdog overrides any wait state that has stalled too long
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (bus.mem_ready)  state_d = DECODE;
        else if (timedOut)  state_d = ERROR;
      end
      DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECUTER;
          OP_ITYPE:          state_d = EXECUTEI;
          OP_BRANCH:         state_d = BEQ;
          OP_JAL:            state_d = JAL;
`ifdef JALR_SUPPORT_EN
          OP_JALR:           state_d = JALR_ADR;
`endif
          default:           state_d = ERROR;
        endcase
      end
      MEMADR:   state_d = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD: begin
        if (bus.mem_ready)  state_d = MEMWB;
        else if (timedOut)  state_d = ERROR;
      end
      MEMWB:    state_d = FETCH;
      MEMWRITE: begin
        if (bus.mem_ready)  state_d = FETCH;
        else if (timedOut)  state_d = ERROR;
      end
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      JAL:      state_d = ALUWB;
`ifdef JALR_SUPPORT_EN
      JALR_ADR: state_d = JALR_JMP;
      JALR_JMP: state_d = ALUWB;
`endif
      ERROR:    state_d = ERROR;
      default:  state_d = ERROR;
    endcase
  end

  // Watchdog count restarts on any state change or completed access
  always_comb begin
    waitCnt_d = '0;
    if ((state_d == state_q) && waitState && !bus.mem_ready) begin
      waitCnt_d = waitCnt_q + 4'd1;
    end
  end

  // State, watchdog, sticky fault and registered control word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      waitCnt_q <= '0;
      err_q     <= 1'b0;
      ctrl_q    <= ctrlFor(FETCH);
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      err_q     <= err_q | (state_d == ERROR);
      ctrl_q    <= ctrlFor(state_d);
    end
  end

  // Fetch strobes are also held off while reset is asserted so an aborted
  // instruction never loads PC/IR on a stray mem_ready.
  assign bus.PCWrite    = ctrl_q.pcWrite
                        | (ctrl_q.pcWriteOnReady & bus.mem_ready & ~reset)
                        | (ctrl_q.pcWriteOnZero & bus.Zero);
  assign bus.IRWrite    = ctrl_q.irWriteOnReady & bus.mem_ready & ~reset;
  assign bus.AdrSrc     = ctrl_q.adrSrc;
  assign bus.MemWrite   = ctrl_q.memWrite;
  assign bus.RegWrite   = ctrl_q.regWrite;
  assign bus.ResultSrc  = ctrl_q.resultSrc;
  assign bus.ALUSrcA    = ctrl_q.aluSrcA;
  assign bus.ALUSrcB    = ctrl_q.aluSrcB;
  assign bus.ALUOp      = ctrl_q.aluOp;
  assign bus.instr_done = ctrl_q.doneAlways | (ctrl_q.doneOnReady & bus.mem_ready);
  assign bus.err        = err_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller built with MEM_TIMEOUT=3.
// Expected state codes and control words are hand-derived constants.
// The control word packs, MSB first:
// {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
//  ALUSrcB, ALUOp, instr_done, err}.

module tb_multicycle_controller;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
`ifdef JALR_SUPPORT_EN
  localparam logic [3:0] S_JALR_ADR = 4'd11;
  localparam logic [3:0] S_JALR_JMP = 4'd12;
`endif
  localparam logic [3:0] S_ERROR    = 4'd13;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  //                                   PAMIR _RS_SA_SB_OP_DE
  localparam logic [14:0] C_FETCH_IDLE = 15'b00000_10_00_10_00_00;
  localparam logic [14:0] C_FETCH_RDY  = 15'b10010_10_00_10_00_00;
  localparam logic [14:0] C_DECODE     = 15'b00000_00_01_01_00_00;
  localparam logic [14:0] C_MEMADR     = 15'b00000_00_10_01_00_00;
  localparam logic [14:0] C_MEMREAD    = 15'b01000_00_00_00_00_00;
  localparam logic [14:0] C_MEMWB      = 15'b00001_01_00_00_00_10;
  localparam logic [14:0] C_MEMWR_WAIT = 15'b01100_00_00_00_00_00;
  localparam logic [14:0] C_MEMWR_DONE = 15'b01100_00_00_00_00_10;
  localparam logic [14:0] C_EXECUTER   = 15'b00000_00_10_00_10_00;
  localparam logic [14:0] C_EXECUTEI   = 15'b00000_00_10_01_10_00;
  localparam logic [14:0] C_ALUWB      = 15'b00001_00_00_00_00_10;
  localparam logic [14:0] C_BEQ_TAKEN  = 15'b10000_00_10_00_01_10;
  localparam logic [14:0] C_BEQ_NOT    = 15'b00000_00_10_00_01_10;
  localparam logic [14:0] C_JAL        = 15'b10000_00_01_10_00_00;
`ifdef JALR_SUPPORT_EN
  localparam logic [14:0] C_JALR_ADR   = 15'b00000_00_10_01_00_00;
  localparam logic [14:0] C_JALR_JMP   = 15'b10000_00_01_10_00_00;
`endif
  localparam logic [14:0] C_ERROR      = 15'b00000_00_00_00_00_01;

  logic clk;
  logic reset;
  int   checkCount;
  int   errorCount;

  multicycle_controller_if bus();

  multicycle_controller #(.MEM_TIMEOUT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [14:0] ctrlVec;
  assign ctrlVec = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                    bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                    bus.instr_done, bus.err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs, check state and controls mid-cycle, then advance one clock
  task automatic applyStimulus(input string tag, input logic [6:0] opV, input logic zeroV,
                               input logic readyV, input logic [3:0] expState,
                               input logic [14:0] expCtrl);
    bus.op        = opV;
    bus.Zero      = zeroV;
    bus.mem_ready = readyV;
    #1;
    checkOutput({tag, ".state"}, {12'd0, bus.state}, {12'd0, expState});
    checkOutput({tag, ".ctrl"},  {1'b0, ctrlVec},    {1'b0, expCtrl});
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset(input string tag);
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput({tag, ".state"}, {12'd0, bus.state}, {12'd0, S_FETCH});
    checkOutput({tag, ".ctrl"},  {1'b0, ctrlVec},    {1'b0, C_FETCH_IDLE});
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    checkCount    = 0;
    errorCount    = 0;
    reset         = 1'b1;
    bus.op        = OP_R;
    bus.Zero      = 1'b0;
    bus.mem_ready = 1'b0;

    @(posedge clk);
    #1;
    checkOutput("rst.state", {12'd0, bus.state}, {12'd0, S_FETCH});
    checkOutput("rst.ctrl",  {1'b0, ctrlVec},    {1'b0, C_FETCH_IDLE});
    bus.mem_ready = 1'b1;
    #1;
    checkOutput("rst.rdyGated", {1'b0, ctrlVec}, {1'b0, C_FETCH_IDLE});
    @(posedge clk);
    #1;
    reset = 1'b0;

    // R-type, no waits
    applyStimulus("r.fetch",   OP_R, 1'b0, 1'b1, S_FETCH,    C_FETCH_RDY);
    applyStimulus("r.decode",  OP_R, 1'b0, 1'b1, S_DECODE,   C_DECODE);
    applyStimulus("r.exec",    OP_R, 1'b0, 1'b1, S_EXECUTER, C_EXECUTER);
    applyStimulus("r.wb",      OP_R, 1'b0, 1'b1, S_ALUWB,    C_ALUWB);

    // lw, three wait cycles per access; the completing cycle hits the timeout count
    for (int i = 0; i < 3; i++)
      applyStimulus("lw.fetchWait", OP_LW, 1'b0, 1'b0, S_FETCH, C_FETCH_IDLE);
    applyStimulus("lw.fetchRdy", OP_LW, 1'b0, 1'b1, S_FETCH,  C_FETCH_RDY);
    applyStimulus("lw.decode",   OP_LW, 1'b0, 1'b0, S_DECODE, C_DECODE);
    applyStimulus("lw.memadr",   OP_LW, 1'b0, 1'b0, S_MEMADR, C_MEMADR);
    for (int i = 0; i < 3; i++)
      applyStimulus("lw.readWait", OP_LW, 1'b0, 1'b0, S_MEMREAD, C_MEMREAD);
    applyStimulus("lw.readRdy",  OP_LW, 1'b0, 1'b1, S_MEMREAD, C_MEMREAD);
    applyStimulus("lw.wb",       OP_LW, 1'b0, 1'b0, S_MEMWB,   C_MEMWB);

    // sw, one wait then completion
    applyStimulus("sw.fetch",    OP_SW, 1'b0, 1'b1, S_FETCH,    C_FETCH_RDY);
    applyStimulus("sw.decode",   OP_SW, 1'b0, 1'b0, S_DECODE,   C_DECODE);
    applyStimulus("sw.memadr",   OP_SW, 1'b0, 1'b0, S_MEMADR,   C_MEMADR);
    applyStimulus("sw.wrWait",   OP_SW, 1'b0, 1'b0, S_MEMWRITE, C_MEMWR_WAIT);
    applyStimulus("sw.wrDone",   OP_SW, 1'b0, 1'b1, S_MEMWRITE, C_MEMWR_DONE);

    // I-type ALU
    applyStimulus("i.fetch",  OP_I, 1'b0, 1'b1, S_FETCH,    C_FETCH_RDY);
    applyStimulus("i.decode", OP_I, 1'b0, 1'b0, S_DECODE,   C_DECODE);
    applyStimulus("i.exec",   OP_I, 1'b0, 1'b0, S_EXECUTEI, C_EXECUTEI);
    applyStimulus("i.wb",     OP_I, 1'b0, 1'b0, S_ALUWB,    C_ALUWB);

    // beq taken and not taken
    applyStimulus("beq1.fetch",  OP_BEQ, 1'b0, 1'b1, S_FETCH,  C_FETCH_RDY);
    applyStimulus("beq1.decode", OP_BEQ, 1'b0, 1'b0, S_DECODE, C_DECODE);
    applyStimulus("beq1.beq",    OP_BEQ, 1'b1, 1'b0, S_BEQ,    C_BEQ_TAKEN);
    applyStimulus("beq0.fetch",  OP_BEQ, 1'b0, 1'b1, S_FETCH,  C_FETCH_RDY);
    applyStimulus("beq0.decode", OP_BEQ, 1'b0, 1'b0, S_DECODE, C_DECODE);
    applyStimulus("beq0.beq",    OP_BEQ, 1'b0, 1'b0, S_BEQ,    C_BEQ_NOT);

    // jal
    applyStimulus("jal.fetch",  OP_JAL, 1'b0, 1'b1, S_FETCH,  C_FETCH_RDY);
    applyStimulus("jal.decode", OP_JAL, 1'b0, 1'b0, S_DECODE, C_DECODE);
    applyStimulus("jal.jal",    OP_JAL, 1'b0, 1'b0, S_JAL,    C_JAL);
    applyStimulus("jal.wb",     OP_JAL, 1'b0, 1'b0, S_ALUWB,  C_ALUWB);

    // jalr: full sequence when supported, illegal otherwise
    applyStimulus("jalr.fetch",  OP_JALR, 1'b0, 1'b1, S_FETCH,  C_FETCH_RDY);
    applyStimulus("jalr.decode", OP_JALR, 1'b0, 1'b0, S_DECODE, C_DECODE);
`ifdef JALR_SUPPORT_EN
    applyStimulus("jalr.adr",    OP_JALR, 1'b0, 1'b0, S_JALR_ADR, C_JALR_ADR);
    applyStimulus("jalr.jmp",    OP_JALR, 1'b0, 1'b0, S_JALR_JMP, C_JALR_JMP);
    applyStimulus("jalr.wb",     OP_JALR, 1'b0, 1'b0, S_ALUWB,    C_ALUWB);
`else
    applyStimulus("jalr.err",    OP_JALR, 1'b0, 1'b0, S_ERROR, C_ERROR);
    pulseReset("jalr.rst");
`endif

    // Illegal opcode; ERROR is sticky regardless of inputs
    applyStimulus("bad.fetch",  OP_BAD, 1'b0, 1'b1, S_FETCH,  C_FETCH_RDY);
    applyStimulus("bad.decode", OP_BAD, 1'b0, 1'b0, S_DECODE, C_DECODE);
    applyStimulus("bad.err0",   OP_BAD, 1'b0, 1'b0, S_ERROR,  C_ERROR);
    applyStimulus("bad.err1",   OP_R,   1'b1, 1'b1, S_ERROR,  C_ERROR);
    pulseReset("bad.rst");

    // MemWrite stall hits the timeout after four cycles in MEMWRITE
    applyStimulus("to.fetch",  OP_SW, 1'b0, 1'b1, S_FETCH,  C_FETCH_RDY);
    applyStimulus("to.decode", OP_SW, 1'b0, 1'b0, S_DECODE, C_DECODE);
    applyStimulus("to.memadr", OP_SW, 1'b0, 1'b0, S_MEMADR, C_MEMADR);
    for (int i = 0; i < 4; i++)
      applyStimulus("to.wrWait", OP_SW, 1'b0, 1'b0, S_MEMWRITE, C_MEMWR_WAIT);
    applyStimulus("to.err0",   OP_SW, 1'b0, 1'b0, S_ERROR, C_ERROR);
    applyStimulus("to.err1",   OP_SW, 1'b0, 1'b1, S_ERROR, C_ERROR);
    pulseReset("to.rst");

    // Reset in the middle of a MEMWRITE cycle, away from any clock edge
    applyStimulus("mr.fetch",  OP_SW, 1'b0, 1'b1, S_FETCH,  C_FETCH_RDY);
    applyStimulus("mr.decode", OP_SW, 1'b0, 1'b0, S_DECODE, C_DECODE);
    applyStimulus("mr.memadr", OP_SW, 1'b0, 1'b0, S_MEMADR, C_MEMADR);
    bus.mem_ready = 1'b0;
    #1;
    checkOutput("mr.wrBefore", {1'b0, ctrlVec}, {1'b0, C_MEMWR_WAIT});
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mr.state", {12'd0, bus.state}, {12'd0, S_FETCH});
    checkOutput("mr.ctrl",  {1'b0, ctrlVec},    {1'b0, C_FETCH_IDLE});
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Normal operation resumes after the abort
    applyStimulus("post.fetch",  OP_R, 1'b0, 1'b1, S_FETCH,  C_FETCH_RDY);
    applyStimulus("post.decode", OP_R, 1'b0, 1'b1, S_DECODE, C_DECODE);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, meaning: max consecutive wait cycles with mem_ready=0 before fault; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  7  opcode field of the instruction register.
REQ-005 Zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory completes the current access this cycle.
REQ-007 PCWrite  output  1  PC register enable.
REQ-008 AdrSrc  output  1  memory address select: 0=PC, 1=Result.
REQ-009 MemWrite  output  1  memory write enable.
REQ-010 IRWrite  output  1  instruction-register and OldPC enable.
REQ-011 RegWrite  output  1  register-file write enable.
REQ-012 ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult.
REQ-013 ALUSrcA  output  2  00=PC, 01=OldPC, 10=RD1.
REQ-014 ALUSrcB  output  2  00=RD2, 01=ImmExt, 10=constant 4.
REQ-015 ALUOp  output  2  00=add, 01=subtract, 10=decode from funct.
REQ-016 state  output  4  current FSM state, for debug.
REQ-017 instr_done  output  1  one-cycle pulse on the final cycle of each instruction.
REQ-018 err  output  1  sticky fault flag.

Function
REQ-019 Moore FSM, states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, JALR_ADR, JALR_JMP, ERROR; all control outputs are 0 unless listed below.
REQ-020 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCWrite=mem_ready; stay while mem_ready=0; go to DECODE on mem_ready=1.
REQ-021 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
REQ-022 DECODE transitions by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; 1100111 -> JALR_ADR (see Configuration); any other op -> ERROR.
REQ-023 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; next state is MEMREAD if op=0000011, otherwise MEMWRITE.
REQ-024 MEMREAD: ResultSrc=00, AdrSrc=1; hold until mem_ready=1, then go to MEMWB.
REQ-025 MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
REQ-026 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 held high while waiting; -> FETCH on mem_ready=1.
REQ-027 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
REQ-028 EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
REQ-029 ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
REQ-030 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero -> FETCH.
REQ-031 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 -> ALUWB.
REQ-032 instr_done=1 in MEMWB, ALUWB and BEQ, and in MEMWRITE when mem_ready=1.
REQ-033 Wait counter: 4 bits, cleared on every state change and whenever mem_ready=1; increments each cycle spent in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
REQ-034 If the wait counter equals MEM_TIMEOUT while mem_ready=0, the next state is ERROR.
REQ-035 A mem_ready=1 arriving in the same cycle the counter reaches MEM_TIMEOUT completes the access normally; no fault is raised.
REQ-036 ERROR: all control outputs 0, err=1; remains in ERROR until reset.

Reset
REQ-037 On reset assertion, immediately and asynchronously: state=FETCH, wait counter=0, err=0.
REQ-038 A reset asserted mid-instruction, including during MemWrite, aborts the instruction; outputs take their FETCH values with mem_ready=0 (PCWrite=0, IRWrite=0).
REQ-039 The first FETCH access begins on the first rising clk edge after reset deasserts.

Configuration
REQ-040 Macro JALR_SUPPORT_EN: when defined, op=1100111 in DECODE goes to JALR_ADR.
REQ-041 JALR_ADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 -> JALR_JMP.
REQ-042 JALR_JMP: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 -> ALUWB.
REQ-043 When JALR_SUPPORT_EN is undefined, the JALR_ADR and JALR_JMP states are absent and op=1100111 -> ERROR.

Verification
REQ-044 R-type: op=0110011, mem_ready=1 always -> FETCH, DECODE, EXECUTER, ALUWB; RegWrite=1 in cycle 4; instr_done is a single pulse.
REQ-045 lw with 3 wait cycles per access: op=0000011 -> FETCH held 4 cycles, IRWrite=1 only in the 4th cycle; MEMREAD held 4 cycles; then MEMWB with RegWrite=1.
REQ-046 beq: op=1100011 with Zero=1 -> PCWrite=1 in BEQ; with Zero=0 -> PCWrite=0 in BEQ.
REQ-047 Timeout: MEM_TIMEOUT=3, mem_ready held 0 during MEMWRITE -> ERROR entered after 4 cycles in MEMWRITE; err=1 and stays 1 until reset.
REQ-048 Illegal opcode: op=1111111 -> ERROR after DECODE; with op=1100111 -> JALR_ADR, JALR_JMP, ALUWB when JALR_SUPPORT_EN is defined, ERROR otherwise.
REQ-049 Reset asserted mid-cycle in MEMWRITE -> MemWrite drops to 0 without waiting for a clk edge; state=FETCH; err=0.
